cnt_readout_serializer: RTL

- Downstream consumer of the SPI block's counter-readout selects, `load_cnt_ser` (one-hot channel) and `select_reg` (byte index).
- On an `inst_readout` pulse it waits a settle interval, then snapshots all channel counters into shadow registers.
- It then serializes the selected shadow byte, MSB first, on `cnt_ser_out`. The SPI block forwards that bit stream to its `serial_out` during reads of registers 4-59.

---
 rtl/cnt_readout_serializer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/cnt_readout_serializer.sv
// rtl/cnt_readout_serializer.sv - counter snapshot capture and MSB-first byte serializer for SPI readout
module cnt_readout_serializer #(
  parameter int NUM_CH     = 8,
  parameter int CNT_W      = 56,
  parameter int SETTLE_CYC = 4
) (
  input  logic                    sclk,
  input  logic                    rst,
  input  logic                    inst_rst,
  input  logic                    inst_readout,
  input  logic [NUM_CH*CNT_W-1:0] cnt_in,
  input  logic [NUM_CH-1:0]       load_cnt_ser,
  input  logic [2:0]              select_reg,
  output logic                    cnt_ser_out,
  output logic                    data_valid,
  output logic                    capture_busy
);

  localparam int         NUM_BYTES   = CNT_W / 8;
  localparam logic [3:0] NUM_BYTES_L = 4'(NUM_BYTES);
  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_VALID
  } state_t;

  state_t                    state;
  logic [7:0]                settle_cnt;
  logic [NUM_CH*CNT_W-1:0]   shadow;
  logic [7:0]                shift_reg;
  logic [NUM_CH-1:0]         load_q;
  logic [2:0]                select_q;
  logic                      sel_onehot;
  logic                      sel_valid;
  logic                      sel_changed;
  logic [7:0]                sel_byte;

  // Capture FSM: settle delay after a readout request, then one-cycle snapshot of all channels
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      settle_cnt   <= 8'd0;
      data_valid   <= 1'b0;
      capture_busy <= 1'b0;
      shadow       <= '0;
    end else if (inst_rst) begin
      state        <= ST_IDLE;
      settle_cnt   <= 8'd0;
      data_valid   <= 1'b0;
      capture_busy <= 1'b0;
      shadow       <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_VALID: begin
          if (inst_readout) begin
            state        <= ST_SETTLE;
            settle_cnt   <= SETTLE_INIT;
            data_valid   <= 1'b0;
            capture_busy <= 1'b1;
          end
        end
        ST_SETTLE: begin
          // A repeated request restarts the settle interval rather than queueing
          if (inst_readout) begin
            settle_cnt <= SETTLE_INIT;
          end else if (settle_cnt == 8'd0) begin
            state <= ST_CAPTURE;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
        ST_CAPTURE: begin
          shadow       <= cnt_in;
          state        <= ST_VALID;
          data_valid   <= 1'b1;
          capture_busy <= 1'b0;
        end
        default: begin
          state        <= ST_IDLE;
          capture_busy <= 1'b0;
        end
      endcase
    end
  end

  // Selection decode: exactly one channel and an in-range byte index
  always_comb begin
    sel_onehot  = (load_cnt_ser != '0) &&
                  ((load_cnt_ser & (load_cnt_ser - 1'b1)) == '0);
    sel_valid   = sel_onehot && ({1'b0, select_reg} < NUM_BYTES_L);
    sel_changed = (load_cnt_ser != load_q) || (select_reg != select_q);
    sel_byte    = 8'h00;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int k = 0; k < NUM_BYTES; k++) begin
        if (load_cnt_ser[c] && (select_reg == 3'(k))) begin
          sel_byte = sel_byte | shadow[c*CNT_W + 8*k +: 8];
        end
      end
    end
  end

  // Serializer: reload on a new valid selection, shift while it holds, clear when idle
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      shift_reg <= 8'h00;
      load_q    <= '0;
      select_q  <= 3'd7;
    end else if (inst_rst) begin
      shift_reg <= 8'h00;
      load_q    <= '0;
      select_q  <= 3'd7;
    end else begin
      load_q   <= load_cnt_ser;
      select_q <= select_reg;
      if (sel_valid && sel_changed) begin
        shift_reg <= sel_byte;
      end else if (sel_valid) begin
        shift_reg <= {shift_reg[6:0], 1'b0};
      end else begin
        shift_reg <= 8'h00;
      end
    end
  end

  assign cnt_ser_out = shift_reg[7];

endmodule
